// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam logic       SIZE_WORD = 1'b0;
  localparam logic       SIZE_BYTE = 1'b1;
  localparam logic [3:0] BE_WORD   = 4'hF;

  // One-hot lane enable for a byte store at the given offset.
  function automatic logic [3:0] byte_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: store replication and enables, lbu extraction from the read word.
module mem_lane_steer
  import mem_pkg::*;
(
  input  logic        size,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic        rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  always_comb begin
    be = BE_WORD;
    if (we && (size == SIZE_BYTE)) begin
      be = byte_be(off);
    end
    wdata_out = (size == SIZE_BYTE) ? {4{wdata[7:0]}} : wdata;
    // Load side uses the offset/size captured at issue, not the live inputs.
    rdata_out = bus_rdata;
    if (rd_size == SIZE_BYTE) begin
      rdata_out = {24'b0, bus_rdata[{rd_off, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage responder: one load/store becomes a req/ack bus transaction while the pipeline stalls.
// Handshake: bus_req stays high with stable bus_we/addr/be/wdata until the cycle bus_ack=1; that cycle completes it.
module mem_stage_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_data_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              align_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ms_state_e         state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [1:0]        off_q, off_d;
  logic              size_q, size_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        access, illegal, stall_c, align_err_c;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata, steer_rdata;

  mem_lane_steer u_steer (
    .size      (mem_data_size),
    .we        (mem_write),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .rd_size   (size_q),
    .rd_off    (off_q),
    .bus_rdata (bus_rdata),
    .be        (steer_be),
    .wdata_out (steer_wdata),
    .rdata_out (steer_rdata)
  );

  assign access  = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) |
                   ((mem_data_size == SIZE_WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    align_err_c = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      MS_IDLE: begin
        rdata_d = '0;
        if (access) begin
          if (illegal) begin
            align_err_c = 1'b1;
          end else begin
            stall_c     = 1'b1;
            state_d     = MS_BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = steer_be;
            bus_wdata_d = steer_wdata;
            off_d       = addr[1:0];
            size_d      = mem_data_size;
            cnt_d       = '0;
          end
        end
      end
      MS_BUSY: begin
        stall_c = 1'b1;
        // An ack in the final allowed cycle takes priority over the timeout.
        if (bus_ack) begin
          rdata_d   = steer_rdata;
          bus_req_d = 1'b0;
          state_d   = MS_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err   = 1'b1;
          rdata_d   = '0;
          bus_req_d = 1'b0;
          state_d   = MS_DONE;
        end else begin
          cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      MS_DONE: begin
        rdata_d = '0;
        state_d = MS_IDLE;
      end
      default: begin
        state_d   = MS_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MS_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= SIZE_WORD;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall     = stall_c & rst_n;
  assign align_err = align_err_c & rst_n;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit: table of accesses plus timeout and reset sequences.
module tb_mem_stage_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_data_size;
  logic [31:0] addr, wdata;
  logic        stall, align_err, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          ack_at;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[14];

  mem_stage_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_size(mem_data_size),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .align_err(align_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_read      = v.rd;
    mem_write     = v.wr;
    mem_data_size = v.sz;
    addr          = v.addr;
    wdata         = v.wdata;
  endtask

  task automatic drive_idle();
    mem_read = 0; mem_write = 0; mem_data_size = 0; addr = 0; wdata = 0;
  endtask

  // Access cycle, BUSY cycles with ack at BUSY cycle v.ack_at (0 = never), then DONE.
  task automatic run_txn(input vec_t v);
    int  stalls;
    bit  timed_out;
    @(negedge clk);
    drive(v);
    bus_ack = 0;
    #1;
    if (!v.legal) begin
      check("illegal_align_err", align_err, 1);
      check("illegal_stall", stall, 0);
      check("illegal_req", bus_req, 0);
      check("illegal_rdata", rdata, 0);
      return;
    end
    check("access_stall", stall, 1);
    check("access_align_err", align_err, 0);
    check("access_req_idle", bus_req, 0);
    stalls    = (stall === 1'b1) ? 1 : 0;
    timed_out = 0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      bus_ack   = (n == v.ack_at);
      bus_rdata = v.brdata;
      #1;
      if (stall === 1'b1) stalls++;
      check("busy_req", bus_req, 1);
      check("busy_err", bus_err, ((n == TIMEOUT) && (v.ack_at != n)) ? 1 : 0);
      if (n == 1) begin
        check("bus_we", bus_we, v.wr);
        check("bus_addr", bus_addr, v.baddr);
        check("bus_be", bus_be, v.be);
        if (v.wr) check("bus_wdata", bus_wdata, v.bwdata);
      end
      if (n == v.ack_at) break;
      if (n == TIMEOUT) timed_out = 1;
    end
    @(negedge clk);
    bus_ack   = 0;
    bus_rdata = 32'h5555_AAAA;
    #1;
    check("done_stall", stall, 0);
    check("done_req", bus_req, 0);
    check("done_rdata", rdata, timed_out ? 32'h0 : v.rdata);
    check("stall_cycles", stalls, timed_out ? TIMEOUT + 1 : v.ack_at + 1);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    drive_idle();
    bus_ack = 0;
    #1;
    check({name, "_stall"}, stall, 0);
    check({name, "_req"}, bus_req, 0);
    check({name, "_rdata"}, rdata, 0);
    check({name, "_state"}, state_dbg, 0);
  endtask

  initial begin
    vec_t v;
    //          rd wr sz addr          wdata         brdata      ack legal be    baddr         bwdata        rdata
    vecs[0]  = '{1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1, 0, 1, 32'h103, 32'h0,        32'h11223344, 1, 1, 4'hF, 32'h100, 32'h0,        32'h00000011};
    vecs[2]  = '{0, 1, 1, 32'h202, 32'h000000AB, 32'h0,        1, 1, 4'h4, 32'h200, 32'hABABABAB, 32'h0};
    vecs[3]  = '{0, 1, 1, 32'h201, 32'h12345678, 32'h0,        3, 1, 4'h2, 32'h200, 32'h78787878, 32'h0};
    vecs[4]  = '{0, 1, 0, 32'h300, 32'hCAFEF00D, 32'h0,        1, 1, 4'hF, 32'h300, 32'hCAFEF00D, 32'h0};
    vecs[5]  = '{1, 0, 1, 32'h101, 32'h0,        32'h11223344, 2, 1, 4'hF, 32'h100, 32'h0,        32'h00000033};
    vecs[6]  = '{1, 0, 1, 32'h100, 32'h0,        32'hA5B6C7D8, 3, 1, 4'hF, 32'h100, 32'h0,        32'h000000D8};
    vecs[7]  = '{1, 0, 1, 32'h102, 32'h0,        32'hA5B6C7D8, 1, 1, 4'hF, 32'h100, 32'h0,        32'h000000B6};
    vecs[8]  = '{0, 1, 0, 32'h101, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[9]  = '{1, 0, 0, 32'h102, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[10] = '{1, 1, 0, 32'h100, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[11] = '{0, 1, 1, 32'h203, 32'h0000005A, 32'h0,        1, 1, 4'h8, 32'h200, 32'h5A5A5A5A, 32'h0};
    vecs[12] = '{1, 0, 0, 32'h104, 32'h0,        32'h01020304, 1, 1, 4'hF, 32'h104, 32'h0,        32'h01020304};
    vecs[13] = '{1, 1, 1, 32'h101, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        32'h0};

    // Clock/reset
    rst_n = 0;
    drive_idle();
    bus_ack = 0;
    bus_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", bus_req, 0);
    check("rst_rdata", rdata, 0);
    check("rst_align_err", align_err, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_be", bus_be, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) run_txn(vecs[i]);
    check_idle("after_table");

    // Timeout with no ack, then ack landing in the last allowed cycle.
    v = '{1, 0, 0, 32'h400, 32'h0, 32'h0BADF00D, 0, 1, 4'hF, 32'h400, 32'h0, 32'h0};
    run_txn(v);
    check_idle("after_timeout");
    v = '{1, 0, 0, 32'h400, 32'h0, 32'h0BADF00D, TIMEOUT, 1, 4'hF, 32'h400, 32'h0, 32'h0BADF00D};
    run_txn(v);
    check_idle("after_late_ack");

    // Reset in the middle of BUSY.
    @(negedge clk);
    mem_read = 1; mem_data_size = 0; addr = 32'h500;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_req", bus_req, 1);
    rst_n = 0;
    #1;
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_state", state_dbg, 0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1;
    check_idle("after_rst");

    // Fresh lw, then back-to-back sw and lw.
    run_txn(vecs[12]);
    run_txn(vecs[4]);
    run_txn(vecs[0]);
    check_idle("after_b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
